// File: rtl/fm_voice_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fm_voice_pkg : shared types for the FM voice allocator               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fm_voice_pkg;

  localparam int MIDI_NOTE_W = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } alloc_state_t;

  typedef struct packed {
    logic                   note_on;
    logic [MIDI_NOTE_W-1:0] note;
    logic [MIDI_NOTE_W-1:0] velocity;
  } midi_event_t;

endpackage
`default_nettype wire

// File: rtl/fm_voice_allocator_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fm_voice_allocator_if : MIDI event valid/ready channel               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface fm_voice_allocator_if;
  import fm_voice_pkg::*;

  logic                   ev_valid;
  logic                   ev_ready;
  logic                   ev_note_on;
  logic [MIDI_NOTE_W-1:0] ev_note;
  logic [MIDI_NOTE_W-1:0] ev_velocity;

  modport master (output ev_valid, ev_note_on, ev_note, ev_velocity, input ev_ready);
  modport slave  (input ev_valid, ev_note_on, ev_note, ev_velocity, output ev_ready);

endinterface
`default_nettype wire

// File: rtl/fm_voice_slot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fm_voice_slot : note/velocity/gate/age/trig state of one voice       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fm_voice_slot
  import fm_voice_pkg::*;
#(
  parameter int AGEW = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   assign_i,
  input  logic                   release_i,
  input  logic                   age_inc_i,
  input  logic                   clear_gate_i,
  input  logic [MIDI_NOTE_W-1:0] note_i,
  input  logic [MIDI_NOTE_W-1:0] vel_i,
  output logic [MIDI_NOTE_W-1:0] note_o,
  output logic [MIDI_NOTE_W-1:0] vel_o,
  output logic                   gate_o,
  output logic                   trig_o,
  output logic [AGEW-1:0]        age_o
);

  logic [MIDI_NOTE_W-1:0] note_q, note_d, vel_q, vel_d;
  logic                   gate_q, gate_d, trig_q, trig_d;
  logic [AGEW-1:0]        age_q, age_d;

  always_comb begin
    note_d = note_q;
    vel_d  = vel_q;
    gate_d = gate_q;
    age_d  = age_q;
    trig_d = 1'b0;
    // Panic clears gates only; note, velocity and age survive for release tails.
    if (clear_gate_i) begin
      gate_d = 1'b0;
    end else if (assign_i) begin
      note_d = note_i;
      vel_d  = vel_i;
      gate_d = 1'b1;
      age_d  = '0;
      trig_d = 1'b1;
    end else begin
      if (release_i) gate_d = 1'b0;
      if (age_inc_i && (age_q != {AGEW{1'b1}})) age_d = age_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      note_q <= '0;
      vel_q  <= '0;
      gate_q <= 1'b0;
      trig_q <= 1'b0;
      age_q  <= '0;
    end else begin
      note_q <= note_d;
      vel_q  <= vel_d;
      gate_q <= gate_d;
      trig_q <= trig_d;
      age_q  <= age_d;
    end
  end

  assign note_o = note_q;
  assign vel_o  = vel_q;
  assign gate_o = gate_q;
  assign trig_o = trig_q;
  assign age_o  = age_q;

endmodule
`default_nettype wire

// File: rtl/fm_voice_allocator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fm_voice_allocator : retrigger / free / steal-oldest voice allocator |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fm_voice_allocator
  import fm_voice_pkg::*;
#(
  parameter int NUMVOICES = 4,
  parameter int AGEW      = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  fm_voice_allocator_if.slave        ev,
  input  logic                       all_notes_off,
  output logic [MIDI_NOTE_W-1:0]     voice_notes    [0:NUMVOICES-1],
  output logic [MIDI_NOTE_W-1:0]     voice_velocity [0:NUMVOICES-1],
  output logic [NUMVOICES-1:0]       voice_gate,
  output logic [NUMVOICES-1:0]       voice_trig
);

  localparam int c_idx_w = $clog2(NUMVOICES);
  typedef logic [c_idx_w-1:0] idx_t;

  alloc_state_t    state_q, state_d;
  idx_t            idx_q, idx_d;
  idx_t            match_idx_q, match_idx_d, free_idx_q, free_idx_d;
  idx_t            oldest_idx_q, oldest_idx_d, w_target;
  logic            match_found_q, match_found_d, free_found_q, free_found_d;
  logic [AGEW-1:0] oldest_age_q, oldest_age_d;
  midi_event_t     ev_q, ev_d;

  logic [AGEW-1:0]      w_age [0:NUMVOICES-1];
  logic [NUMVOICES-1:0] w_assign, w_release, w_age_inc;
  logic                 w_first, w_last, w_match_prev, w_free_prev;

  assign ev.ev_ready    = (state_q == IDLE) && !all_notes_off && !reset;
  assign w_first        = (idx_q == '0);
  assign w_last         = (idx_q == idx_t'(NUMVOICES - 1));
  // Trackers restart at idx 0 so stale results from the previous event never leak in.
  assign w_match_prev   = match_found_q && !w_first;
  assign w_free_prev    = free_found_q && !w_first;
  assign w_target       = match_found_q ? match_idx_q : (free_found_q ? free_idx_q : oldest_idx_q);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    ev_d          = ev_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    oldest_idx_d  = oldest_idx_q;
    oldest_age_d  = oldest_age_q;
    w_assign      = '0;
    w_release     = '0;
    w_age_inc     = '0;
    case (state_q)
      IDLE: begin
        if (ev.ev_valid && ev.ev_ready) begin
          ev_d.note_on  = ev.ev_note_on && (ev.ev_velocity != '0);
          ev_d.note     = ev.ev_note;
          ev_d.velocity = ev.ev_velocity;
          idx_d         = '0;
          state_d       = SCAN;
        end
      end
      SCAN: begin
        match_found_d = w_match_prev;
        free_found_d  = w_free_prev;
        if (!w_match_prev && voice_gate[idx_q] && (voice_notes[idx_q] == ev_q.note)) begin
          match_found_d = 1'b1;
          match_idx_d   = idx_q;
        end
        if (!w_free_prev && !voice_gate[idx_q]) begin
          free_found_d = 1'b1;
          free_idx_d   = idx_q;
        end
        if (w_first || (w_age[idx_q] > oldest_age_q)) begin
          oldest_idx_d = idx_q;
          oldest_age_d = w_age[idx_q];
        end
        if (w_last) state_d = COMMIT;
        else        idx_d   = idx_q + 1'b1;
      end
      COMMIT: begin
        state_d = IDLE;
        if (ev_q.note_on) begin
          for (int i = 0; i < NUMVOICES; i++) begin
            w_assign[i]  = (idx_t'(i) == w_target);
            w_age_inc[i] = (idx_t'(i) != w_target);
          end
        end else if (match_found_q) begin
          w_release[match_idx_q] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (all_notes_off) begin
      state_d   = IDLE;
      w_assign  = '0;
      w_release = '0;
      w_age_inc = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      ev_q          <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      oldest_idx_q  <= '0;
      oldest_age_q  <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      ev_q          <= ev_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      oldest_idx_q  <= oldest_idx_d;
      oldest_age_q  <= oldest_age_d;
    end
  end

  for (genvar i = 0; i < NUMVOICES; i++) begin : g_slot
    fm_voice_slot #(.AGEW(AGEW)) u_slot (
      .clk          (clk),
      .reset        (reset),
      .assign_i     (w_assign[i]),
      .release_i    (w_release[i]),
      .age_inc_i    (w_age_inc[i]),
      .clear_gate_i (all_notes_off),
      .note_i       (ev_q.note),
      .vel_i        (ev_q.velocity),
      .note_o       (voice_notes[i]),
      .vel_o        (voice_velocity[i]),
      .gate_o       (voice_gate[i]),
      .trig_o       (voice_trig[i]),
      .age_o        (w_age[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_fm_voice_allocator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fm_voice_allocator : directed + random bench with allocation model|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fm_voice_allocator;

  localparam int NV     = 4;
  localparam int AGEW   = 8;
  localparam int AGEMAX = (1 << AGEW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          all_notes_off;
  logic [6:0]    voice_notes    [0:NV-1];
  logic [6:0]    voice_velocity [0:NV-1];
  logic [NV-1:0] voice_gate, voice_trig;

  fm_voice_allocator_if bus ();

  fm_voice_allocator #(.NUMVOICES(NV), .AGEW(AGEW)) dut (
    .clk            (clk),
    .reset          (reset),
    .ev             (bus),
    .all_notes_off  (all_notes_off),
    .voice_notes    (voice_notes),
    .voice_velocity (voice_velocity),
    .voice_gate     (voice_gate),
    .voice_trig     (voice_trig)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain per-voice arrays updated once per completed event.
  int            m_note [NV];
  int            m_vel  [NV];
  bit            m_gate [NV];
  int            m_age  [NV];
  logic [NV-1:0] m_trig;
  logic [NV-1:0] last_trig;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_event(input bit on, input int note, input int vel);
    int  match, free, oldest, tgt;
    match  = -1;
    free   = -1;
    oldest = 0;
    for (int i = 0; i < NV; i++) begin
      if (match < 0 && m_gate[i] && m_note[i] == note) match = i;
      if (free < 0 && !m_gate[i]) free = i;
      if (m_age[i] > m_age[oldest]) oldest = i;
    end
    m_trig = '0;
    if (on && vel != 0) begin
      tgt = (match >= 0) ? match : ((free >= 0) ? free : oldest);
      for (int i = 0; i < NV; i++) begin
        if (i == tgt) begin
          m_note[i] = note;
          m_vel[i]  = vel;
          m_gate[i] = 1'b1;
          m_age[i]  = 0;
        end else if (m_age[i] < AGEMAX) begin
          m_age[i]++;
        end
      end
      m_trig[tgt] = 1'b1;
    end else if (match >= 0) begin
      m_gate[match] = 1'b0;
    end
  endfunction

  function automatic logic [NV-1:0] model_gates();
    logic [NV-1:0] g;
    for (int i = 0; i < NV; i++) g[i] = m_gate[i];
    return g;
  endfunction

  task automatic check_all();
    for (int i = 0; i < NV; i++) begin
      chk("voice_note", voice_notes[i], m_note[i]);
      chk("voice_vel", voice_velocity[i], m_vel[i]);
    end
    chk("voice_gate", voice_gate, model_gates());
    chk("voice_trig", voice_trig, m_trig);
  endtask

  // anf_at > 0 raises all_notes_off at that many negedges after acceptance.
  task automatic do_event(input bit on, input int note, input int vel, input int anf_at);
    int lowc;
    @(negedge clk);
    bus.ev_valid    = 1'b1;
    bus.ev_note_on  = on;
    bus.ev_note     = 7'(note);
    bus.ev_velocity = 7'(vel);
    chk("hs_ready", bus.ev_ready, 1);
    @(posedge clk);
    #1;
    bus.ev_valid    = 1'b0;
    bus.ev_note     = 7'($urandom_range(0, 127));
    bus.ev_velocity = 7'($urandom_range(0, 127));
    if (anf_at > 0) begin
      repeat (anf_at) @(negedge clk);
      all_notes_off = 1'b1;
      @(posedge clk);
      #1;
      chk("anf_gate", voice_gate, 0);
      chk("anf_trig", voice_trig, 0);
      chk("anf_ready", bus.ev_ready, 0);
      for (int i = 0; i < NV; i++) m_gate[i] = 1'b0;
      m_trig = '0;
      @(negedge clk);
      all_notes_off = 1'b0;
      #1;
      chk("anf_ready_back", bus.ev_ready, 1);
      check_all();
      return;
    end
    lowc = 0;
    @(negedge clk);
    while (!bus.ev_ready && lowc < 20) begin
      lowc++;
      @(negedge clk);
    end
    chk("busy_cycles", lowc, NV + 1);
    model_event(on, note, vel);
    last_trig = voice_trig;
    check_all();
    @(negedge clk);
    chk("trig_pulse_end", voice_trig, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    all_notes_off   = 1'b0;
    bus.ev_valid    = 1'b0;
    bus.ev_note_on  = 1'b0;
    bus.ev_note     = '0;
    bus.ev_velocity = '0;
    for (int i = 0; i < NV; i++) begin
      m_note[i] = 0; m_vel[i] = 0; m_gate[i] = 1'b0; m_age[i] = 0;
    end
    m_trig = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.ev_ready, 0);
    check_all();
    reset = 1'b0;
    #1;
    chk("post_rst_ready", bus.ev_ready, 1);

    do_event(1, 60, 100, 0);
    chk("first_note", voice_notes[0], 60);
    chk("first_vel", voice_velocity[0], 100);
    chk("first_trig", last_trig, 4'b0001);

    do_event(1, 62, 80, 0);
    do_event(1, 64, 81, 0);
    do_event(1, 65, 82, 0);
    chk("filled_gates", voice_gate, 4'b1111);
    do_event(1, 67, 83, 0);
    chk("steal_note", voice_notes[0], 67);
    chk("steal_trig", last_trig, 4'b0001);

    do_event(1, 62, 50, 0);
    chk("retrig_vel", voice_velocity[1], 50);
    chk("retrig_trig", last_trig, 4'b0010);

    do_event(0, 64, 10, 0);
    chk("off_gate", voice_gate[2], 0);
    chk("off_note_kept", voice_notes[2], 64);
    do_event(0, 70, 10, 0);
    do_event(1, 67, 0, 0);
    chk("vel0_off", voice_gate[0], 0);

    do_event(1, 72, 90, 0);
    chk("free_used", voice_notes[0], 72);
    chk("free_trig", last_trig, 4'b0001);

    do_event(1, 74, 90, 2);
    do_event(1, 75, 91, NV + 1);

    // Voice 0 is never retriggered, so only a saturating age keeps it oldest.
    do_event(1, 40, 1, 0);
    do_event(1, 41, 2, 0);
    do_event(1, 42, 3, 0);
    do_event(1, 43, 4, 0);
    for (int i = 0; i < 254; i++) do_event(1, 41 + (i % 3), 5, 0);
    do_event(1, 50, 6, 0);
    chk("sat_steal", voice_notes[0], 50);

    for (int i = 0; i < 80; i++) begin
      int anf;
      anf = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, NV + 1)) : 0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_event($urandom_range(0, 3) != 0, 60 + int'($urandom_range(0, 7)),
               ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 127)), anf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
